// File: rtl/dmem_access_ctrl_if.sv
// Requester-side bus of the data-memory access controller: one instance per port (C, D).
// master = requester, slave = controller.
interface dmem_access_ctrl_if #(
    parameter int AW = 32
) ();
    logic          req;
    logic          we;
    logic [1:0]    size;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic          ack;
    logic          err;
    logic [31:0]   rdata;

    modport master (output req, we, size, addr, wdata, input  ack, err, rdata);
    modport slave  (input  req, we, size, addr, wdata, output ack, err, rdata);
endinterface

// File: rtl/dmem_access_ctrl.sv
// Two-port sequencer/arbiter in front of a word-write-only data memory; sub-word stores become RMW.
// Optional DMEM_ACC_STATS_EN adds a saturating simultaneous-request counter (conflict_cnt_o).
module dmem_access_ctrl #(
    parameter int AW = 32
`ifdef DMEM_ACC_STATS_EN
    , parameter int STAT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst,
    dmem_access_ctrl_if.slave c_bus,
    dmem_access_ctrl_if.slave d_bus,
    output logic              mem_we_o,
    output logic [AW-1:0]     mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i
`ifdef DMEM_ACC_STATS_EN
    , output logic [STAT_W-1:0] conflict_cnt_o
`endif
);
    typedef enum logic [1:0] {IDLE, ACCESS, MERGE, DONE} state_e;

    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    state_e        state_q, state_d;
    logic          gnt_q, gnt_d;
    logic          last_gnt_q, last_gnt_d;
    logic          we_q, we_d;
    logic [1:0]    size_q, size_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   merge_q, merge_d;
    logic          err_q, err_d;
    logic [31:0]   c_rdata_q, c_rdata_d;
    logic [31:0]   d_rdata_q, d_rdata_d;

    logic          both_req;
    logic          sel;
    logic          sel_we;
    logic [1:0]    sel_size;
    logic [AW-1:0] sel_addr;
    logic [31:0]   sel_wdata;
    logic          sel_misaligned;

    function automatic logic [31:0] load_lane(logic [31:0] w, logic [1:0] sz, logic [1:0] off);
        logic [31:0] sh;
        sh = w >> {off, 3'b000};
        case (sz)
            2'b00:   return {24'b0, sh[7:0]};
            2'b01:   return {16'b0, sh[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] merge_lane(logic [31:0] w, logic [31:0] d, logic [1:0] sz,
                                               logic [1:0] off);
        logic [31:0] m;
        m = (sz == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF;
        return (w & ~(m << {off, 3'b000})) | ((d & m) << {off, 3'b000});
    endfunction

    // Round robin on conflict: last_gnt resets to D so C takes the first conflict.
    always_comb begin
        both_req  = c_bus.req & d_bus.req;
        sel       = both_req ? ~last_gnt_q : d_bus.req;
        sel_we    = sel ? d_bus.we    : c_bus.we;
        sel_size  = sel ? d_bus.size  : c_bus.size;
        sel_addr  = sel ? d_bus.addr  : c_bus.addr;
        sel_wdata = sel ? d_bus.wdata : c_bus.wdata;
        sel_misaligned = (sel_size == 2'b11) ||
                         (sel_size == 2'b01 && sel_addr[0]) ||
                         (sel_size == 2'b10 && sel_addr[1:0] != 2'b00);
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        last_gnt_d = last_gnt_q;
        we_d       = we_q;
        size_d     = size_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        merge_d    = merge_q;
        err_d      = err_q;
        c_rdata_d  = c_rdata_q;
        d_rdata_d  = d_rdata_q;
        case (state_q)
            IDLE: begin
                if (c_bus.req || d_bus.req) begin
                    gnt_d      = sel;
                    last_gnt_d = sel;
                    we_d       = sel_we;
                    size_d     = sel_size;
                    addr_d     = sel_addr;
                    wdata_d    = sel_wdata;
                    err_d      = sel_misaligned;
                    state_d    = ACCESS;
                end
            end
            ACCESS: begin
                // An errored access still spends its ACCESS cycle (memory idle) to keep latency uniform.
                state_d = DONE;
                if (!err_q) begin
                    if (!we_q) begin
                        if (gnt_q == PORT_D) d_rdata_d = load_lane(mem_rdata_i, size_q, addr_q[1:0]);
                        else                 c_rdata_d = load_lane(mem_rdata_i, size_q, addr_q[1:0]);
                    end else if (size_q != 2'b10) begin
                        merge_d = mem_rdata_i;
                        state_d = MERGE;
                    end
                end
            end
            MERGE:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            gnt_q      <= PORT_C;
            last_gnt_q <= PORT_D;
            we_q       <= 1'b0;
            size_q     <= 2'b00;
            addr_q     <= '0;
            wdata_q    <= '0;
            merge_q    <= '0;
            err_q      <= 1'b0;
            c_rdata_q  <= '0;
            d_rdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            last_gnt_q <= last_gnt_d;
            we_q       <= we_d;
            size_q     <= size_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            merge_q    <= merge_d;
            err_q      <= err_d;
            c_rdata_q  <= c_rdata_d;
            d_rdata_q  <= d_rdata_d;
        end
    end

    // Memory strobes decode straight from state so an async reset drops mem_we immediately.
    assign mem_addr_o  = {addr_q[AW-1:2], 2'b00};
    assign mem_we_o    = (state_q == MERGE) ||
                         (state_q == ACCESS && we_q && !err_q && size_q == 2'b10);
    assign mem_wdata_o = (state_q == MERGE) ? merge_lane(merge_q, wdata_q, size_q, addr_q[1:0])
                                            : wdata_q;

    assign c_bus.ack   = (state_q == DONE) && (gnt_q == PORT_C);
    assign c_bus.err   = c_bus.ack && err_q;
    assign c_bus.rdata = c_rdata_q;
    assign d_bus.ack   = (state_q == DONE) && (gnt_q == PORT_D);
    assign d_bus.err   = d_bus.ack && err_q;
    assign d_bus.rdata = d_rdata_q;

`ifdef DMEM_ACC_STATS_EN
    logic [STAT_W-1:0] conflict_q, conflict_d;

    always_comb begin
        conflict_d = conflict_q;
        if (state_q == IDLE && both_req && conflict_q != '1) conflict_d = conflict_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) conflict_q <= '0;
        else     conflict_q <= conflict_d;
    end

    assign conflict_cnt_o = conflict_q;
`endif
endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: vector table plus arbitration and reset-during-RMW sequences,
// with a per-port scoreboard checked on every ack. Build with DMEM_ACC_STATS_EN to cover conflict_cnt.
module tb_dmem_access_ctrl;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
`ifdef DMEM_ACC_STATS_EN
    logic [15:0]   conflict_cnt;
`endif

    always #5 clk = ~clk;

    dmem_access_ctrl_if #(.AW(AW)) c_if ();
    dmem_access_ctrl_if #(.AW(AW)) d_if ();

    dmem_access_ctrl #(.AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .c_bus       (c_if),
        .d_bus       (d_if),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata)
`ifdef DMEM_ACC_STATS_EN
        , .conflict_cnt_o (conflict_cnt)
`endif
    );

    // Small word memory with combinational read, covering 0x1001_0000..0x1001_00FF.
    logic [31:0] tbmem [0:63] = '{default: 32'h0};
    assign mem_rdata = tbmem[mem_addr[7:2]];
    always @(posedge clk) if (mem_we) tbmem[mem_addr[7:2]] <= mem_wdata;

    typedef struct {
        bit          err;
        logic [31:0] rdata;
        bit          chk_rd;
    } exp_t;

    typedef struct {
        bit          p;
        bit          we;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        bit          err;
        logic [31:0] rd;
        bit          chk_rd;
        int          lat;
        int          wen;
    } vec_t;

    exp_t cq[$];
    exp_t dq[$];
    int   nvec = 0;
    int   nmis = 0;
    int   we_cnt = 0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            exp_t e;
            if (mem_we) we_cnt++;
            if (c_if.ack || d_if.ack) chk("ack_exclusive", {31'b0, c_if.ack & d_if.ack}, 32'h0);
            if (c_if.ack) begin
                chk("c_ack_expected", 32'(cq.size() != 0), 32'h1);
                if (cq.size() != 0) begin
                    e = cq.pop_front();
                    chk("c_err", {31'b0, c_if.err}, {31'b0, e.err});
                    if (e.chk_rd) chk("c_rdata", c_if.rdata, e.rdata);
                end
            end
            if (d_if.ack) begin
                chk("d_ack_expected", 32'(dq.size() != 0), 32'h1);
                if (dq.size() != 0) begin
                    e = dq.pop_front();
                    chk("d_err", {31'b0, d_if.err}, {31'b0, e.err});
                    if (e.chk_rd) chk("d_rdata", d_if.rdata, e.rdata);
                end
            end
        end
    end

    task automatic drive(input bit p, input bit rq, input bit we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
        if (p) begin
            d_if.req = rq; d_if.we = we; d_if.size = sz; d_if.addr = a; d_if.wdata = wd;
        end else begin
            c_if.req = rq; c_if.we = we; c_if.size = sz; c_if.addr = a; c_if.wdata = wd;
        end
    endtask

    task automatic do_req(input vec_t v, input string nm);
        exp_t e;
        int   cyc;
        bit   got;
        e.err = v.err; e.rdata = v.rd; e.chk_rd = v.chk_rd;
        if (v.p) dq.push_back(e); else cq.push_back(e);
        @(posedge clk); #1;
        drive(v.p, 1'b1, v.we, v.sz, v.a, v.wd);
        we_cnt = 0;
        cyc = 0; got = 0;
        while (!got && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (v.p ? d_if.ack : c_if.ack) got = 1;
        end
        chk({nm, "_latency"}, got ? cyc : -1, v.lat);
        chk({nm, "_mem_we_cycles"}, we_cnt, v.wen);
        if (!got) begin
            if (v.p) void'(dq.pop_back()); else void'(cq.pop_back());
        end
        @(posedge clk); #1;
        drive(v.p, 1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    vec_t vt [19];
    vec_t v;
    int   order [4];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //        p  we sz     addr           wdata          err rdata          chk lat wen
        vt[0]  = '{0, 1, 2'b10, 32'h1001_0004, 32'hDEAD_BEEF, 0, 32'h0,         0, 3, 1};
        vt[1]  = '{0, 0, 2'b10, 32'h1001_0004, 32'h0,         0, 32'hDEAD_BEEF, 1, 3, 0};
        vt[2]  = '{0, 1, 2'b00, 32'h1001_0006, 32'h0000_0055, 0, 32'h0,         0, 4, 1};
        vt[3]  = '{0, 0, 2'b10, 32'h1001_0004, 32'h0,         0, 32'hDE55_BEEF, 1, 3, 0};
        vt[4]  = '{0, 0, 2'b01, 32'h1001_0006, 32'h0,         0, 32'h0000_DE55, 1, 3, 0};
        vt[5]  = '{0, 0, 2'b00, 32'h1001_0005, 32'h0,         0, 32'h0000_00BE, 1, 3, 0};
        vt[6]  = '{0, 1, 2'b10, 32'h1001_0002, 32'hFFFF_FFFF, 1, 32'h0,         0, 3, 0};
        vt[7]  = '{0, 0, 2'b10, 32'h1001_0000, 32'h0,         0, 32'h0000_0000, 1, 3, 0};
        vt[8]  = '{1, 1, 2'b10, 32'h1001_0008, 32'h1122_3344, 0, 32'h0,         0, 3, 1};
        vt[9]  = '{1, 1, 2'b01, 32'h1001_000A, 32'hAAAA_BBBB, 0, 32'h0,         0, 4, 1};
        vt[10] = '{1, 0, 2'b10, 32'h1001_0008, 32'h0,         0, 32'hBBBB_3344, 1, 3, 0};
        vt[11] = '{1, 1, 2'b00, 32'h1001_000B, 32'h1234_56CC, 0, 32'h0,         0, 4, 1};
        vt[12] = '{1, 0, 2'b10, 32'h1001_0008, 32'h0,         0, 32'hCCBB_3344, 1, 3, 0};
        vt[13] = '{1, 0, 2'b00, 32'h1001_000B, 32'h0,         0, 32'h0000_00CC, 1, 3, 0};
        vt[14] = '{0, 0, 2'b01, 32'h1001_0001, 32'h0,         1, 32'h0,         0, 3, 0};
        vt[15] = '{0, 0, 2'b11, 32'h1001_0004, 32'h0,         1, 32'h0,         0, 3, 0};
        vt[16] = '{1, 1, 2'b00, 32'h1001_0008, 32'h0000_005A, 0, 32'h0,         0, 4, 1};
        vt[17] = '{1, 0, 2'b01, 32'h1001_0008, 32'h0,         0, 32'h0000_335A, 1, 3, 0};
        vt[18] = '{0, 0, 2'b00, 32'h1001_0007, 32'h0,         0, 32'h0000_00DE, 1, 3, 0};

        drive(0, 0, 0, 2'b00, 32'h0, 32'h0);
        drive(1, 0, 0, 2'b00, 32'h0, 32'h0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_c_ack", {31'b0, c_if.ack}, 32'h0);
        chk("rst_d_ack", {31'b0, d_if.ack}, 32'h0);
        chk("rst_c_err", {31'b0, c_if.err}, 32'h0);
        chk("rst_mem_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_c_rdata", c_if.rdata, 32'h0);
        chk("rst_d_rdata", d_if.rdata, 32'h0);
`ifdef DMEM_ACC_STATS_EN
        chk("rst_conflict_cnt", {16'b0, conflict_cnt}, 32'h0);
`endif
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 19; i++) do_req(vt[i], $sformatf("vec%0d", i));

        // Both ports request continuously from reset: grants must alternate C,D,C,D.
        apply_reset();
        for (int k = 0; k < 2; k++) begin
            cq.push_back('{0, 32'hDE55_BEEF, 1});
            dq.push_back('{0, 32'h0, 0});
        end
        @(posedge clk); #1;
        drive(0, 1, 0, 2'b10, 32'h1001_0004, 32'h0);
        drive(1, 1, 1, 2'b10, 32'h1001_0020, 32'h0000_00A0);
        begin
            int n;
            int cyc;
            n = 0; cyc = 0;
            while (n < 4 && cyc < 40) begin
                @(negedge clk);
                cyc++;
                if (c_if.ack && n < 4) begin order[n] = 0; n++; end
                if (d_if.ack && n < 4) begin order[n] = 1; n++; end
            end
            chk("arb_acks_seen", n, 4);
            for (int k = 0; k < 4; k++) chk($sformatf("arb_order%0d", k), order[k], k % 2);
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 2'b00, 32'h0, 32'h0);
        drive(1, 0, 0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
`ifdef DMEM_ACC_STATS_EN
        chk("conflict_cnt", {16'b0, conflict_cnt}, 32'h4);
`endif
        v = '{1, 0, 2'b10, 32'h1001_0020, 32'h0, 0, 32'h0000_00A0, 1, 3, 0};
        do_req(v, "arb_dstore_readback");

        // Reset while the RMW write is on the bus: strobe drops at once, no ack, write lost.
        @(posedge clk); #1;
        drive(0, 1, 1, 2'b00, 32'h1001_0010, 32'h0000_0077);
        repeat (3) @(negedge clk);
        chk("rmw_merge_we", {31'b0, mem_we}, 32'h1);
        #1 rst = 1'b1;
        #1;
        chk("rst_mid_rmw_we", {31'b0, mem_we}, 32'h0);
        chk("rst_mid_rmw_ack", {31'b0, c_if.ack}, 32'h0);
        repeat (2) @(posedge clk);
        #1 drive(0, 0, 0, 2'b00, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        chk("rst_mid_rmw_rdata", c_if.rdata, 32'h0);
        v = '{0, 0, 2'b10, 32'h1001_0004, 32'h0, 0, 32'hDE55_BEEF, 1, 3, 0};
        do_req(v, "post_rst_load");
        v = '{0, 0, 2'b10, 32'h1001_0010, 32'h0, 0, 32'h0000_0000, 1, 3, 0};
        do_req(v, "lost_write_check");

        repeat (2) @(negedge clk);
        chk("c_queue_drained", cq.size(), 0);
        chk("d_queue_drained", dq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
